// File: rtl/link_sweep_ctrl_pkg.sv
// Shared types for the link sweep sequencer.
//   sweep_state_t  : sequencer FSM states
//   sweep_result_t : one streamed result record (default widths)
//   state_busy()   : true in every state that belongs to an active sweep
package link_sweep_ctrl_pkg;

  localparam int unsigned TX_SETTING_WIDTH = 4;
  localparam int unsigned RX_SETTING_WIDTH = 4;
  localparam int unsigned ERR_WIDTH        = 16;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    HOLD,
    RUN,
    REPORT,
    NEXT,
    DONE
  } sweep_state_t;

  typedef struct packed {
    logic [TX_SETTING_WIDTH-1:0] tx;
    logic [RX_SETTING_WIDTH-1:0] rx;
    logic [ERR_WIDTH-1:0]        errs;
  } sweep_result_t;

  function automatic logic state_busy(sweep_state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/link_sweep_ctrl_if.sv
// Result-record stream between the sweep sequencer and its consumer.
//   res_valid/res_ready : valid/ready handshake
//   res_tx/res_rx       : grid point of the record
//   res_errs            : bit-error count measured at that point
// master = sequencer side, slave = consumer side.
interface link_sweep_ctrl_if
  import link_sweep_ctrl_pkg::*;
#(
  parameter int unsigned TX_W  = TX_SETTING_WIDTH,
  parameter int unsigned RX_W  = RX_SETTING_WIDTH,
  parameter int unsigned ERR_W = ERR_WIDTH
);

  logic             res_valid;
  logic             res_ready;
  logic [TX_W-1:0]  res_tx;
  logic [RX_W-1:0]  res_rx;
  logic [ERR_W-1:0] res_errs;

  modport master (
    output res_valid, res_tx, res_rx, res_errs,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_tx, res_rx, res_errs,
    output res_ready
  );

endinterface

// File: rtl/link_sweep_ctrl_sat_counter.sv
// Saturating up-counter used for the per-point bit-error count.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the count (wins over inc)
//   inc        : add one, holding at all-ones
//   count      : registered count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/link_sweep_ctrl.sv
// Sweep sequencer: walks a TX (outer) x RX (inner) equalisation grid, resetting
// and running the emulated link at each point, streaming one error-count record
// per point and tracking the lowest-error point.
//   clk, rst_n                 : clock, synchronous active-low reset
//   start, abort               : sweep control (abort wins over everything)
//   tx/rx_first/last, run_cycles : grid and run length, latched on start
//   tx_setting, rx_setting     : settings driven to the link under test
//   dut_rst                    : active-high reset to the link under test
//   dut_done, err_pulse        : early-finish and per-cycle bit-error inputs
//   res                        : result record stream (master)
//   busy, done                 : sweep status (done sticky until next start)
//   best_tx/rx/errs            : best point seen in the current sweep
module link_sweep_ctrl
  import link_sweep_ctrl_pkg::*;
#(
  parameter int unsigned TX_W    = TX_SETTING_WIDTH,
  parameter int unsigned RX_W    = RX_SETTING_WIDTH,
  parameter int unsigned RUN_W   = 24,
  parameter int unsigned ERR_W   = ERR_WIDTH,
  parameter int unsigned RST_CYC = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TX_W-1:0]   tx_first,
  input  logic [TX_W-1:0]   tx_last,
  input  logic [RX_W-1:0]   rx_first,
  input  logic [RX_W-1:0]   rx_last,
  input  logic [RUN_W-1:0]  run_cycles,
  output logic [TX_W-1:0]   tx_setting,
  output logic [RX_W-1:0]   rx_setting,
  output logic              dut_rst,
  input  logic              dut_done,
  input  logic              err_pulse,
  link_sweep_ctrl_if.master res,
  output logic              busy,
  output logic              done,
  output logic [TX_W-1:0]   best_tx,
  output logic [RX_W-1:0]   best_rx,
  output logic [ERR_W-1:0]  best_errs
);

  localparam int unsigned HOLD_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam int unsigned CNT_W  = (RUN_W > HOLD_W) ? RUN_W : HOLD_W;

  sweep_state_t     state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_plus1;
  logic [TX_W-1:0]  tx_last_q;
  logic [RX_W-1:0]  rx_first_q;
  logic [RX_W-1:0]  rx_last_q;
  logic [RUN_W-1:0] run_q;
  logic [ERR_W-1:0] err_cnt;
  logic             res_valid_q;

  logic cnt_clr, cnt_inc, ld_cfg, xfer;

  assign cnt_plus1 = cnt + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and datapath strobes
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    ld_cfg     = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ld_cfg     = 1'b1;
          next_state = ((tx_first > tx_last) || (rx_first > rx_last)) ? DONE : APPLY;
        end
      end
      APPLY: begin
        cnt_clr    = 1'b1;
        next_state = HOLD;
      end
      HOLD: begin
        if (cnt == CNT_W'(RST_CYC - 1)) begin
          cnt_clr    = 1'b1;
          next_state = (run_q == '0) ? REPORT : RUN;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RUN: begin
        cnt_inc = 1'b1;
        // dut_done cycle still counts: err counter samples this same cycle
        if (dut_done || (cnt_plus1 == CNT_W'(run_q))) next_state = REPORT;
      end
      REPORT: begin
        if (res.res_ready) begin
          xfer       = 1'b1;
          next_state = NEXT;
        end
      end
      NEXT: begin
        next_state = ((tx_setting == tx_last_q) && (rx_setting == rx_last_q)) ? DONE : APPLY;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // abort drops any pending record and leaves done clear
    if (abort && state_busy(state)) begin
      next_state = IDLE;
      xfer       = 1'b0;
    end
  end

  // Cycle counter shared by HOLD and RUN
  always_ff @(posedge clk) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_inc) cnt <= cnt_plus1;
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == APPLY),
    .inc   ((state == RUN) && err_pulse),
    .count (err_cnt)
  );

  // Config latch, grid stepping, best tracking and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_last_q   <= '0;
      rx_first_q  <= '0;
      rx_last_q   <= '0;
      run_q       <= '0;
      tx_setting  <= '0;
      rx_setting  <= '0;
      dut_rst     <= 1'b1;
      res_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      best_tx     <= '0;
      best_rx     <= '0;
      best_errs   <= '1;
    end else begin
      if (ld_cfg) begin
        tx_last_q  <= tx_last;
        rx_first_q <= rx_first;
        rx_last_q  <= rx_last;
        run_q      <= run_cycles;
        done       <= 1'b0;
        best_tx    <= '0;
        best_rx    <= '0;
        best_errs  <= '1;
      end
      // settings only move on the edge into APPLY
      if (next_state == APPLY) begin
        if (state == IDLE) begin
          tx_setting <= tx_first;
          rx_setting <= rx_first;
        end else if (rx_setting < rx_last_q) begin
          rx_setting <= rx_setting + 1'b1;
        end else begin
          rx_setting <= rx_first_q;
          tx_setting <= tx_setting + 1'b1;
        end
      end
      if (xfer && (err_cnt < best_errs)) begin
        best_tx   <= tx_setting;
        best_rx   <= rx_setting;
        best_errs <= err_cnt;
      end
      if (next_state == DONE) done <= 1'b1;
      busy        <= state_busy(next_state);
      dut_rst     <= (next_state != RUN);
      res_valid_q <= (next_state == REPORT);
    end
  end

  assign res.res_valid = res_valid_q;
  assign res.res_tx    = tx_setting;
  assign res.res_rx    = rx_setting;
  assign res.res_errs  = err_cnt;

endmodule

// File: tb/tb_link_sweep_ctrl.sv
// Self-checking bench for link_sweep_ctrl: scoreboard of expected records,
// one task per scenario.
module tb_link_sweep_ctrl;
  import link_sweep_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // main instance (default widths, RST_CYC=200)
  logic        start, abort, dut_done, err_pulse;
  logic [3:0]  tx_first, tx_last, rx_first, rx_last;
  logic [23:0] run_cycles;
  logic [3:0]  tx_setting, rx_setting, best_tx, best_rx;
  logic        dut_rst, busy, done;
  logic [15:0] best_errs;
  // saturation instance (ERR_W=4, RST_CYC=5)
  logic        start1, abort1, dut_done1, err_pulse1;
  logic [3:0]  tx_first1, tx_last1, rx_first1, rx_last1;
  logic [23:0] run_cycles1;
  logic [3:0]  tx_setting1, rx_setting1, best_tx1, best_rx1;
  logic        dut_rst1, busy1, done1;
  logic [3:0]  best_errs1;

  link_sweep_ctrl_if #(.TX_W(4), .RX_W(4), .ERR_W(16)) rif0 ();
  link_sweep_ctrl_if #(.TX_W(4), .RX_W(4), .ERR_W(4))  rif1 ();

  link_sweep_ctrl #(.TX_W(4), .RX_W(4), .RUN_W(24), .ERR_W(16), .RST_CYC(200)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .tx_first(tx_first), .tx_last(tx_last), .rx_first(rx_first), .rx_last(rx_last),
    .run_cycles(run_cycles), .tx_setting(tx_setting), .rx_setting(rx_setting),
    .dut_rst(dut_rst), .dut_done(dut_done), .err_pulse(err_pulse), .res(rif0.master),
    .busy(busy), .done(done), .best_tx(best_tx), .best_rx(best_rx), .best_errs(best_errs)
  );

  link_sweep_ctrl #(.TX_W(4), .RX_W(4), .RUN_W(24), .ERR_W(4), .RST_CYC(5)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .tx_first(tx_first1), .tx_last(tx_last1), .rx_first(rx_first1), .rx_last(rx_last1),
    .run_cycles(run_cycles1), .tx_setting(tx_setting1), .rx_setting(rx_setting1),
    .dut_rst(dut_rst1), .dut_done(dut_done1), .err_pulse(err_pulse1), .res(rif1.master),
    .busy(busy1), .done(done1), .best_tx(best_tx1), .best_rx(best_rx1), .best_errs(best_errs1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  sweep_result_t exp_q[$];

  task automatic start_sweep(input int txf, input int txl, input int rxf, input int rxl,
                             input int run);
    @(negedge clk);
    tx_first = 4'(txf); tx_last = 4'(txl);
    rx_first = 4'(rxf); rx_last = 4'(rxl);
    run_cycles = 24'(run);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    int t = 0;
    while (dut_rst !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 2000);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL run_wait: dut_rst=%b after %0d cycles, required 0", dut_rst, t);
    end
  endtask

  // pop the next expected record and compare it against the transfer in flight
  task automatic wait_record();
    int t = 0;
    sweep_result_t got, exp_r;
    while (!(rif0.res_valid === 1'b1 && rif0.res_ready === 1'b1) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 5000) begin
      n_bad++;
      $display("FAIL record_wait: res_valid=%b, required 1 within 5000 cycles", rif0.res_valid);
      return;
    end
    got.tx = rif0.res_tx; got.rx = rif0.res_rx; got.errs = rif0.res_errs;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL record_extra: got %h, required no record", got);
    end else begin
      exp_r = exp_q.pop_front();
      if (got !== exp_r) begin
        n_bad++;
        $display("FAIL record: got tx=%0d rx=%0d errs=%0d, required tx=%0d rx=%0d errs=%0d",
                 got.tx, got.rx, got.errs, exp_r.tx, exp_r.rx, exp_r.errs);
      end
    end
    @(negedge clk);
  endtask

  task automatic run_point(input int k);
    bit ok;
    wait_run(ok);
    if (!ok) return;
    if (k > 0) begin
      err_pulse = 1'b1;
      repeat (k) @(negedge clk);
      err_pulse = 1'b0;
    end
    wait_record();
  endtask

  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic run_sweep(input int txf, input int txl, input int rxf, input int rxl,
                           input int run, input int ks[4]);
    int idx = 0;
    logic [15:0] be = 16'hffff;
    logic [3:0]  bt = 4'd0, br = 4'd0;
    sweep_result_t r;
    for (int tx = txf; tx <= txl; tx++) begin
      for (int rx = rxf; rx <= rxl; rx++) begin
        r.tx = 4'(tx); r.rx = 4'(rx); r.errs = 16'(ks[idx]);
        exp_q.push_back(r);
        if (r.errs < be) begin
          be = r.errs; bt = r.tx; br = r.rx;
        end
        idx++;
      end
    end
    start_sweep(txf, txl, rxf, rxl, run);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL sweep_busy: busy=%b, required 1", busy);
    end
    for (int i = 0; i < idx; i++) run_point(ks[i]);
    wait_done();
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL sweep_done: done,busy=%b, required 10", {done, busy});
    end
    n_cmp++;
    if ({best_tx, best_rx, best_errs} !== {bt, br, be}) begin
      n_bad++;
      $display("FAIL sweep_best: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
               best_tx, best_rx, best_errs, bt, br, be);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sweep_leftover: %0d records missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dut_rst, busy, done, rif0.res_valid, tx_setting, rx_setting, best_tx, best_rx, best_errs}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 16'hffff}) begin
      n_bad++;
      $display("FAIL reset_u0: rst=%b busy=%b done=%b valid=%b set=%h/%h best=%h/%h/%h, required 1 0 0 0 0/0 0/0/ffff",
               dut_rst, busy, done, rif0.res_valid, tx_setting, rx_setting, best_tx, best_rx, best_errs);
    end
    n_cmp++;
    if ({dut_rst1, busy1, done1, rif1.res_valid, best_errs1} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'hf}) begin
      n_bad++;
      $display("FAIL reset_u1: rst=%b busy=%b done=%b valid=%b best_errs=%h, required 1 0 0 0 f",
               dut_rst1, busy1, done1, rif1.res_valid, best_errs1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_grid_clean();
    int ks[4];
    ks = '{0, 0, 0, 0};
    run_sweep(2, 3, 0, 1, 100, ks);
  endtask

  task automatic test_err_counts();
    int ks[4];
    ks = '{5, 3, 7, 3};
    run_sweep(2, 3, 0, 1, 100, ks);
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable = 1'b1;
    int t = 0;
    sweep_result_t r;
    r.tx = 4'd1; r.rx = 4'd4; r.errs = 16'd2;
    exp_q.push_back(r);
    rif0.res_ready = 1'b0;
    start_sweep(1, 1, 4, 4, 100);
    wait_run(ok);
    err_pulse = 1'b1;
    repeat (2) @(negedge clk);
    err_pulse = 1'b0;
    while (rif0.res_valid !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rif0.res_valid !== 1'b1 || {rif0.res_tx, rif0.res_rx, rif0.res_errs} !== {r.tx, r.rx, r.errs})
        stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin
      n_bad++;
      $display("FAIL stall_stable: valid=%b rec=%h/%h/%h, required 1 held at %h/%h/%h",
               rif0.res_valid, rif0.res_tx, rif0.res_rx, rif0.res_errs, r.tx, r.rx, r.errs);
    end
    rif0.res_ready = 1'b1;
    wait_record();
    n_cmp++;
    if ({rif0.res_valid, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL stall_next: valid,busy=%b, required 01", {rif0.res_valid, busy});
    end
    wait_done();
    n_cmp++;
    if ({done, best_errs} !== {1'b1, 16'd2}) begin
      n_bad++;
      $display("FAIL stall_done: done=%b best_errs=%0d, required 1 2", done, best_errs);
    end
  endtask

  task automatic test_saturate();
    int t = 0;
    tx_first1 = 4'd0; tx_last1 = 4'd0; rx_first1 = 4'd0; rx_last1 = 4'd0;
    run_cycles1 = 24'd40;
    err_pulse1 = 1'b1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (rif1.res_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if ({rif1.res_valid, rif1.res_tx, rif1.res_rx, rif1.res_errs} !== {1'b1, 4'd0, 4'd0, 4'hf}) begin
      n_bad++;
      $display("FAIL saturate: valid=%b rec=%0d/%0d/%0d, required 1 0/0/15",
               rif1.res_valid, rif1.res_tx, rif1.res_rx, rif1.res_errs);
    end
    err_pulse1 = 1'b0;
    t = 0;
    while (done1 !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if ({done1, best_errs1} !== {1'b1, 4'hf}) begin
      n_bad++;
      $display("FAIL saturate_done: done=%b best_errs=%0d, required 1 15", done1, best_errs1);
    end
  endtask

  task automatic test_early_done();
    bit ok;
    sweep_result_t r;
    r.tx = 4'd5; r.rx = 4'd6; r.errs = 16'd11;
    exp_q.push_back(r);
    start_sweep(5, 5, 6, 6, 1000);
    wait_run(ok);
    err_pulse = 1'b1;
    repeat (10) @(negedge clk);
    dut_done = 1'b1;
    @(negedge clk);
    dut_done = 1'b0;
    err_pulse = 1'b0;
    n_cmp++;
    if (rif0.res_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL early_report: res_valid=%b one cycle after dut_done, required 1", rif0.res_valid);
    end
    wait_record();
    wait_done();
    n_cmp++;
    if ({done, best_tx, best_rx, best_errs} !== {1'b1, 4'd5, 4'd6, 16'd11}) begin
      n_bad++;
      $display("FAIL early_best: done=%b best=(%0d,%0d,%0d), required 1 (5,6,11)",
               done, best_tx, best_rx, best_errs);
    end
  endtask

  task automatic test_abort_reset();
    bit ok;
    int ks[4];
    start_sweep(0, 1, 0, 1, 100);
    repeat (20) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({busy, dut_rst, done, rif0.res_valid} !== 4'b0100) begin
      n_bad++;
      $display("FAIL abort_hold: busy,rst,done,valid=%b, required 0100",
               {busy, dut_rst, done, rif0.res_valid});
    end
    start_sweep(0, 1, 0, 1, 100);
    wait_run(ok);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, dut_rst, done, rif0.res_valid, best_errs} !== {4'b0100, 16'hffff}) begin
      n_bad++;
      $display("FAIL reset_run: busy,rst,done,valid=%b best_errs=%h, required 0100 ffff",
               {busy, dut_rst, done, rif0.res_valid}, best_errs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    ks = '{1, 0, 2, 0};
    run_sweep(0, 1, 0, 1, 100, ks);
  endtask

  task automatic test_empty_grid();
    bit saw_valid = 1'b0;
    start_sweep(3, 2, 0, 1, 100);
    n_cmp++;
    if ({done, busy, best_errs} !== {1'b1, 1'b0, 16'hffff}) begin
      n_bad++;
      $display("FAIL empty_done: done=%b busy=%b best_errs=%h, required 1 0 ffff", done, busy, best_errs);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rif0.res_valid === 1'b1) saw_valid = 1'b1;
    end
    n_cmp++;
    if (saw_valid || done !== 1'b1) begin
      n_bad++;
      $display("FAIL empty_idle: saw_valid=%b done=%b, required 0 1", saw_valid, done);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; dut_done = 1'b0; err_pulse = 1'b0;
    tx_first = '0; tx_last = '0; rx_first = '0; rx_last = '0; run_cycles = '0;
    start1 = 1'b0; abort1 = 1'b0; dut_done1 = 1'b0; err_pulse1 = 1'b0;
    tx_first1 = '0; tx_last1 = '0; rx_first1 = '0; rx_last1 = '0; run_cycles1 = '0;
    rif0.res_ready = 1'b1;
    rif1.res_ready = 1'b1;

    test_reset();
    test_grid_clean();
    test_err_counts();
    test_backpressure();
    test_saturate();
    test_early_done();
    test_abort_reset();
    test_empty_grid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
